// File: rtl/procyon_biu_arbiter.sv
// Arbitrates the single BIU line-transfer port among victim WB, MHQ fill and IFQ fill requesters.
// Define PCYN_BIU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module procyon_biu_arbiter #(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_DC_LINE_SIZE = 1024,
  parameter int OPTN_NUM_REQ      = 3,
  parameter int REQ_IDX_WIDTH     = $clog2(OPTN_NUM_REQ),
  parameter int DC_LINE_WIDTH     = OPTN_DC_LINE_SIZE * 8
) (
  input  logic                                          clk,
  input  logic                                          n_rst,
  input  logic [OPTN_NUM_REQ-1:0]                       i_req_en,
  input  logic [OPTN_NUM_REQ-1:0]                       i_req_we,
  input  logic [OPTN_NUM_REQ-1:0][OPTN_ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [OPTN_NUM_REQ-1:0][DC_LINE_WIDTH-1:0]    i_req_data,
  output logic [OPTN_NUM_REQ-1:0]                       o_req_done,
  output logic [DC_LINE_WIDTH-1:0]                      o_req_data,
  output logic [OPTN_NUM_REQ-1:0]                       o_req_grant,
  output logic                                          o_biu_en,
  output logic                                          o_biu_we,
  output logic [OPTN_ADDR_WIDTH-1:0]                    o_biu_addr,
  output logic [DC_LINE_WIDTH-1:0]                      o_biu_data,
  input  logic                                          i_biu_done,
  input  logic [DC_LINE_WIDTH-1:0]                      i_biu_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t                    state_q, state_d;
  logic [OPTN_NUM_REQ-1:0]   grant_q, grant_d;
  logic [REQ_IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [REQ_IDX_WIDTH-1:0]  start_idx;
  logic [REQ_IDX_WIDTH-1:0]  win_idx;
  logic                      win_vld;
  int unsigned               cand;

`ifdef PCYN_BIU_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [REQ_IDX_WIDTH-1:0] rr_q, rr_d;

  // Pointer moves past the owner as the transaction completes, so the owner goes last next round.
  always_comb begin
    rr_d = rr_q;
    if ((state_q == BUSY) && i_biu_done) begin
      rr_d = (idx_q == REQ_IDX_WIDTH'(OPTN_NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  assign start_idx = rr_q;
`endif

  // First requester at or after start_idx, wrapping modulo OPTN_NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned i = 0; i < OPTN_NUM_REQ; i++) begin
      cand = 32'(start_idx) + i;
      if (cand >= OPTN_NUM_REQ) cand = cand - OPTN_NUM_REQ;
      if (!win_vld && i_req_en[REQ_IDX_WIDTH'(cand)]) begin
        win_vld = 1'b1;
        win_idx = REQ_IDX_WIDTH'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d          = BUSY;
          idx_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      BUSY: begin
        if (i_biu_done) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    o_biu_en    = (state_q == BUSY);
    o_biu_we    = i_req_we[idx_q];
    o_biu_addr  = i_req_addr[idx_q];
    o_biu_data  = i_req_data[idx_q];
    o_req_done  = ((state_q == BUSY) && i_biu_done) ? grant_q : '0;
    o_req_grant = grant_q;
    o_req_data  = i_biu_data;
  end

endmodule

// File: tb/tb_procyon_biu_arbiter.sv
// Directed and randomized bench for procyon_biu_arbiter against a transaction-level reference model.
// Honours PCYN_BIU_ARB_FIXED_PRIO_EN the same way the design does.
module tb_procyon_biu_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LS = 8;
  localparam int DW = LS * 8;

  logic                     clk;
  logic                     n_rst;
  logic [N-1:0]             req_en;
  logic [N-1:0]             req_we;
  logic [N-1:0][AW-1:0]     req_addr;
  logic [N-1:0][DW-1:0]     req_data;
  logic [N-1:0]             o_req_done;
  logic [DW-1:0]            o_req_data;
  logic [N-1:0]             o_req_grant;
  logic                     o_biu_en;
  logic                     o_biu_we;
  logic [AW-1:0]            o_biu_addr;
  logic [DW-1:0]            o_biu_data;
  logic                     biu_done;
  logic [DW-1:0]            biu_data;

  procyon_biu_arbiter #(
    .OPTN_ADDR_WIDTH   (AW),
    .OPTN_DC_LINE_SIZE (LS),
    .OPTN_NUM_REQ      (N)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_req_en    (req_en),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_done  (o_req_done),
    .o_req_data  (o_req_data),
    .o_req_grant (o_req_grant),
    .o_biu_en    (o_biu_en),
    .o_biu_we    (o_biu_we),
    .o_biu_addr  (o_biu_addr),
    .o_biu_data  (o_biu_data),
    .i_biu_done  (biu_done),
    .i_biu_data  (biu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: whether a transfer is active, who owns it, and where the search starts.
  int m_phase    = 0;  // 0 idle, 1 transferring, 2 drain cycle
  int m_owner    = 0;
  int m_ptr      = 0;
  int m_busy_cnt = 0;

  int   obs_order[$];
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_en[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_step();
    if (n_rst) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_busy_cnt = 0;
    end else if (m_phase == 0) begin
      if (req_en != '0) begin
        m_owner = pick(); m_phase = 1; m_busy_cnt = 0;
      end
    end else if (m_phase == 1) begin
      if (biu_done) begin
`ifndef PCYN_BIU_ARB_FIXED_PRIO_EN
        m_ptr = (m_owner + 1) % N;
`endif
        m_phase = 2;
      end else begin
        m_busy_cnt++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic half_a();
    logic [N-1:0] eg;
    @(negedge clk);
    eg = '0;
    if (m_phase != 0) eg[m_owner] = 1'b1;
    chk("biu_en", 64'(o_biu_en), 64'(m_phase == 1));
    chk("grant", 64'(o_req_grant), 64'(eg));
    chk("done", 64'(o_req_done), (m_phase == 1 && biu_done) ? 64'(eg) : 64'd0);
    chk("rdata", 64'(o_req_data), 64'(biu_data));
    if (m_phase == 1) begin
      chk("biu_we", 64'(o_biu_we), 64'(req_we[m_owner]));
      chk("biu_addr", 64'(o_biu_addr), 64'(req_addr[m_owner]));
      chk("biu_wdata", 64'(o_biu_data), 64'(req_data[m_owner]));
    end
    if (o_biu_en && !prev_en) begin
      for (int b = 0; b < N; b++) if (o_req_grant[b]) obs_order.push_back(b);
    end
    prev_en = o_biu_en;
  endtask

  task automatic half_b();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    half_a();
    half_b();
  endtask

  // BIU completes on the fourth transferring cycle.
  task automatic run_resp(input int max_cycles, input int want);
    for (int c = 0; c < max_cycles && obs_order.size() < want; c++) begin
      biu_done = (m_phase == 1 && m_busy_cnt == 3);
      cyc();
    end
    biu_done = 1'b0;
  endtask

  task automatic settle_idle();
    req_en = '0;
    for (int c = 0; c < 20 && m_phase != 0; c++) begin
      biu_done = (m_phase == 1);
      cyc();
    end
    biu_done = 1'b0;
    chk("settle_timeout", 64'(m_phase), 64'd0);
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    cyc();
    n_rst = 1'b0;
  endtask

  int exp_order[4];

  initial begin
    n_rst = 1'b1; req_en = '0; req_we = '0; req_addr = '0; req_data = '0;
    biu_done = 1'b0; biu_data = '0;
    cyc(); cyc();
    n_rst = 1'b0;

    // Single MHQ read
    req_en = 3'b010; req_addr[1] = 32'h1000; req_we = 3'b000;
    cyc();
    half_a();
    chk("mhq_en", 64'(o_biu_en), 64'd1);
    chk("mhq_addr", 64'(o_biu_addr), 64'h1000);
    chk("mhq_we", 64'(o_biu_we), 64'd0);
    half_b();
    biu_done = 1'b1; biu_data = 64'hA5A5_A5A5_A5A5_A5A5;
    half_a();
    chk("mhq_done", 64'(o_req_done), 64'b010);
    chk("mhq_rdata", 64'(o_req_data), 64'hA5A5_A5A5_A5A5_A5A5);
    half_b();
    biu_done = 1'b0; req_en = '0;
    half_a();
    chk("drain_en", 64'(o_biu_en), 64'd0);
    chk("drain_grant", 64'(o_req_grant), 64'b010);
    half_b();
    half_a();
    chk("idle_grant", 64'(o_req_grant), 64'd0);
    half_b();

    // All three requesting continuously
    do_reset();
    obs_order.delete();
    req_en = 3'b111;
    run_resp(80, 4);
`ifdef PCYN_BIU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0};
`endif
    for (int i = 0; i < 4; i++)
      chk("rr_order", 64'(obs_order.size() > i ? obs_order[i] : 99), 64'(exp_order[i]));
    settle_idle();

    // Writeback with grant lock while requester 2 arrives mid-transfer
    req_en = 3'b001; req_we = 3'b001; req_data[0] = 64'hDEAD_BEEF_DEAD_BEEF; req_addr[0] = 32'h2000;
    cyc();
    half_a();
    chk("wb_we", 64'(o_biu_we), 64'd1);
    chk("wb_data", 64'(o_biu_data), 64'hDEAD_BEEF_DEAD_BEEF);
    half_b();
    req_en = 3'b101;
    cyc();
    half_a();
    chk("wb_lock", 64'(o_req_grant), 64'b001);
    half_b();
    req_en = 3'b100;
    half_a();
    chk("wb_lock_drop", 64'(o_req_grant), 64'b001);
    half_b();
    biu_done = 1'b1; req_en = '0;
    cyc();
    settle_idle();

    // Spurious done while idle
    biu_done = 1'b1; biu_data = 64'h1234;
    half_a();
    chk("spur_done", 64'(o_req_done), 64'd0);
    half_b();
    biu_done = 1'b0;
    half_a();
    chk("spur_idle", 64'(o_biu_en), 64'd0);
    half_b();

    // Reset during transfer, then a late done pulse
    req_en = 3'b010;
    cyc(); cyc();
    n_rst = 1'b1;
    cyc();
    n_rst = 1'b0; req_en = '0;
    half_a();
    chk("rst_en", 64'(o_biu_en), 64'd0);
    chk("rst_grant", 64'(o_req_grant), 64'd0);
    half_b();
    biu_done = 1'b1;
    half_a();
    chk("rst_late_done", 64'(o_req_done), 64'd0);
    half_b();
    biu_done = 1'b0;

    // Wrap-around: pointer lands on 2, then requesters 0 and 2 pending
    req_en = 3'b010;
    cyc();
    req_en = '0; biu_done = 1'b1;
    cyc();
    biu_done = 1'b0;
    settle_idle();
    obs_order.delete();
    req_en = 3'b101;
    run_resp(40, 2);
`ifdef PCYN_BIU_ARB_FIXED_PRIO_EN
    exp_order[0] = 0; exp_order[1] = 0;
`else
    exp_order[0] = 2; exp_order[1] = 0;
`endif
    for (int i = 0; i < 2; i++)
      chk("wrap_order", 64'(obs_order.size() > i ? obs_order[i] : 99), 64'(exp_order[i]));
    settle_idle();

    // Randomized traffic, including protocol violations and occasional resets
    for (int c = 0; c < 400; c++) begin
      req_en   = N'($urandom);
      req_we   = N'($urandom);
      for (int r = 0; r < N; r++) begin
        req_addr[r] = $urandom;
        req_data[r] = {$urandom, $urandom};
      end
      biu_done = ($urandom_range(0, 3) == 0);
      biu_data = {$urandom, $urandom};
      n_rst    = ($urandom_range(0, 99) == 0);
      cyc();
    end
    n_rst = 1'b0;
    settle_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
